// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad entry stage: FSM states,
// the row/column to hex key map, and a one-hot row decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_hit_t;

    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Exactly one active row is a valid hit; none or several are rejected as ghosting.
    function automatic row_hit_t onehot_row_index(input logic [3:0] active);
        row_hit_t hit;
        case (active)
            4'b0001: hit = '{valid: 1'b1, idx: 2'd0};
            4'b0010: hit = '{valid: 1'b1, idx: 2'd1};
            4'b0100: hit = '{valid: 1'b1, idx: 2'd2};
            4'b1000: hit = '{valid: 1'b1, idx: 2'd3};
            default: hit = '{valid: 1'b0, idx: 2'd0};
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; RESET_VAL is the idle level.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make meta->q a true two-stage pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hex_keypad_entry.sv
// Scans a 4x4 hex keypad, debounces presses and releases, and shifts accepted
// digits into a 16-bit entry register consumed by the control block.
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    input  logic        clear,
    output logic [15:0] userInput,
    output logic        inputValid,
    output logic [2:0]  digits,
    output logic        key_strobe,
    output logic [3:0]  key_code
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE);

    logic [3:0]       rows_sync;
    logic [DIV_W-1:0] dwell_cnt;
    logic             tick;
    logic [1:0]       col_idx;
    logic [1:0]       row_lat;
    logic [DB_W-1:0]  db_cnt;
    state_t           state, next_state;
    row_hit_t         hit;
    logic             none_low, same_row, db_last;
    logic             col_adv, row_load, db_load, db_inc, accept;
    logic [3:0]       key;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (rows_sync)
    );

    assign tick     = (dwell_cnt == DIV_W'(SCAN_DIV - 1));
    assign hit      = onehot_row_index(~rows_sync);
    assign none_low = &rows_sync;
    assign same_row = hit.valid && (hit.idx == row_lat);
    assign db_last  = (db_cnt == DB_W'(DEBOUNCE - 1));
    assign col_n    = ~(4'b0001 << col_idx);
    assign key      = KEYMAP[row_lat][col_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SCAN;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (tick) begin
            case (state)
                SCAN:     if (hit.valid) next_state = PRESS_DB;
                PRESS_DB: if (!same_row) next_state = SCAN;
                          else if (db_last) next_state = HELD;
                HELD:     if (none_low) next_state = REL_DB;
                REL_DB:   if (!none_low) next_state = HELD;
                          else if (db_last) next_state = SCAN;
                default:  next_state = SCAN;
            endcase
        end
    end

    // NOTE: every control output gets a default first so no latch is inferred.
    always_comb begin
        col_adv  = 1'b0;
        row_load = 1'b0;
        db_load  = 1'b0;
        db_inc   = 1'b0;
        accept   = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (hit.valid) begin
                        row_load = 1'b1;
                        db_load  = 1'b1;
                    end else begin
                        col_adv = 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!same_row)    col_adv = 1'b1;
                    else if (db_last) accept  = 1'b1;
                    else              db_inc  = 1'b1;
                end
                HELD:   if (none_low) db_load = 1'b1;
                REL_DB: begin
                    if (none_low) begin
                        if (db_last) col_adv = 1'b1;
                        else         db_inc  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            row_lat   <= 2'd0;
            db_cnt    <= '0;
        end else begin
            dwell_cnt <= tick ? '0 : dwell_cnt + 1'b1;
            if (col_adv)  col_idx <= col_idx + 2'd1;
            if (row_load) row_lat <= hit.idx;
            if (db_load)      db_cnt <= DB_W'(1);
            else if (db_inc)  db_cnt <= db_cnt + 1'b1;
        end
    end

    // A clear coinciding with an accept empties the register before the new digit lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_strobe <= 1'b0;
            key_code   <= 4'h0;
            userInput  <= 16'h0000;
            digits     <= 3'd0;
            inputValid <= 1'b0;
        end else begin
            key_strobe <= accept;
            if (accept) begin
                key_code   <= key;
                userInput  <= {(clear ? 12'h000 : userInput[11:0]), key};
                digits     <= clear ? 3'd1 : ((digits == 3'd4) ? 3'd4 : digits + 3'd1);
                inputValid <= 1'b1;
            end else if (clear) begin
                userInput  <= 16'h0000;
                digits     <= 3'd0;
                inputValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Scoreboard bench for hex_keypad_entry: a matrix keypad model drives the rows,
// a digit-history model predicts each accepted key, and a monitor checks strobes.
module tb_hex_keypad_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] userInput;
    logic        inputValid;
    logic [2:0]  digits;
    logic        key_strobe;
    logic [3:0]  key_code;

    hex_keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .clear      (clear),
        .userInput  (userInput),
        .inputValid (inputValid),
        .digits     (digits),
        .key_strobe (key_strobe),
        .key_code   (key_code)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    logic [3:0] key_down [4];
    always_comb begin
        for (int r = 0; r < 4; r++) row_n[r] = ~|(key_down[r] & ~col_n);
    end

    // Posedges since the last reset release; sample ticks fall on multiples of SCAN_DIV.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [3:0]  code;
        logic [15:0] entry;
        logic [2:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] hist[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] key_at(input int r, input int c);
        logic [15:0] row_keys;
        case (r)
            0:       row_keys = 16'h123A;
            1:       row_keys = 16'h456B;
            2:       row_keys = 16'h789C;
            default: row_keys = 16'hE0FD;
        endcase
        return row_keys[15 - 4*c -: 4];
    endfunction

    // Expected entry = last (up to four) digits since the last clear, read as a hex number.
    function automatic void model_key(input logic [3:0] k, input logic clr);
        exp_t e;
        int   n, take, v;
        if (clr) hist.delete();
        hist.push_back(k);
        n    = hist.size();
        take = (n < 4) ? n : 4;
        v    = 0;
        for (int i = n - take; i < n; i++) v = v * 16 + int'(hist[i]);
        e.code  = k;
        e.entry = 16'(v);
        e.cnt   = 3'(take);
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: key_code=%0h userInput=%04h, expected no strobe (t=%0t)",
                         key_code, userInput, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("key_code", key_code, e.code);
                check("userInput", userInput, e.entry);
                check("digits", digits, e.cnt);
                check("inputValid", inputValid, 1'b1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int r, input int c, input int hold);
        model_key(key_at(r, c), 1'b0);
        key_down[r][c] = 1'b1;
        idle(hold);
        key_down[r][c] = 1'b0;
        idle(40);
        check("strobe_seen", sb.size(), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        hist.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col_n"}, col_n, 4'b1110);
        check({tag, "_userInput"}, userInput, 16'h0000);
        check({tag, "_inputValid"}, inputValid, 1'b0);
        check({tag, "_digits"}, digits, 3'd0);
        check({tag, "_key_strobe"}, key_strobe, 1'b0);
        check({tag, "_key_code"}, key_code, 4'h0);
    endtask

    // Presses key (r,c) just as the scan reaches the column before it, then returns
    // at the negedge preceding the tick on which the scan first samples the key.
    task automatic press_and_find_detect(input int r, input int c, output bit ok);
        logic [3:0] prev_col, key_col;
        prev_col = ~(4'b0001 << ((c + 3) % 4));
        key_col  = ~(4'b0001 << c);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cyc % SCAN_DIV == 0 && col_n == prev_col) begin
                ok = 1'b1;
                break;
            end
        end
        key_down[r][c] = 1'b1;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (cyc % SCAN_DIV == SCAN_DIV - 1 && col_n == key_col) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        check("detect_window_found", ok, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        logic [3:0] seen;
        bit         ok;

        rst_n = 1'b0;
        clear = 1'b0;
        for (int r = 0; r < 4; r++) key_down[r] = 4'b0000;
        idle(3);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Idle scan: column rotates every SCAN_DIV clocks, nothing is entered.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            check("idle_col_n", col_n, exp_col);
        end
        check("idle_userInput", userInput, 16'h0000);
        check("idle_inputValid", inputValid, 1'b0);

        // Single key: row1/col2 is '6'.
        press_key(1, 2, 40);

        // Sequence 1,2,3,A,5 from empty; fifth digit pushes the oldest out.
        pulse_clear();
        press_key(0, 0, 60);
        press_key(0, 1, 60);
        press_key(0, 2, 60);
        press_key(0, 3, 60);
        press_key(1, 1, 60);

        // Bouncing contact on '0', then a stable hold with no auto-repeat.
        for (int t = 0; t < 10; t++) begin
            key_down[3][1] = (t % 2 == 0);
            idle(SCAN_DIV);
        end
        model_key(key_at(3, 1), 1'b0);
        key_down[3][1] = 1'b1;
        idle(240);
        key_down[3][1] = 1'b0;
        idle(40);
        check("bounce_strobe_seen", sb.size(), 0);

        // Two rows on one column: ghosting rejected and the scan keeps moving.
        key_down[0][3] = 1'b1;
        key_down[2][3] = 1'b1;
        seen = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | ~col_n;
        end
        check("ghost_scan_all_columns", seen, 4'hF);
        key_down[0][3] = 1'b0;
        key_down[2][3] = 1'b0;
        idle(40);

        // Build 00AB, then clear lands on the accept cycle of '7'.
        pulse_clear();
        press_key(0, 3, 60);
        press_key(1, 3, 60);
        model_key(key_at(2, 0), 1'b1);
        press_and_find_detect(2, 0, ok);
        idle(2 * SCAN_DIV);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        idle(20);
        key_down[2][0] = 1'b0;
        idle(40);
        check("clear_accept_strobe_seen", sb.size(), 0);

        // Standalone clear.
        pulse_clear();
        check("clear_userInput", userInput, 16'h0000);
        check("clear_digits", digits, 3'd0);
        check("clear_inputValid", inputValid, 1'b0);

        // Reset asserted mid press-debounce on '8': no strobe, everything back to reset.
        press_and_find_detect(2, 1, ok);
        idle(SCAN_DIV + 1);
        rst_n = 1'b0;
        idle(3);
        check_reset_values("midreset");
        key_down[2][1] = 1'b0;
        hist.delete();
        idle(2);
        rst_n = 1'b1;
        idle(60);
        check("midreset_userInput", userInput, 16'h0000);
        check("final_scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
Front-panel numeric entry stage that sits directly upstream of the CPU control/monitor block. It scans a 4x4 hex matrix keypad, synchronises and debounces key presses, and shifts accepted hex digits into a 16-bit entry register. The entry register drives the control block's userInput/inputValid pair. The control block, or panel glue, pulses clear once a command has consumed the entry.

Parameters:
SCAN_DIV, 1000, clocks per column dwell; one sample tick is taken at the end of each dwell (>=4).
DEBOUNCE, 16, consecutive confirming sample ticks required for both press and release (>=2).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
row_n  input  4  keypad rows, active-low, asynchronous to clk
col_n  output  4  keypad column drive, one-hot active-low
clear  input  1  single-cycle pulse; empties the entry register
userInput  output  16  entry register; the most recent digit is in [3:0]
inputValid  output  1  high while at least one digit has been entered since the last clear/reset
digits  output  3  number of digits entered, saturating at 4
key_strobe  output  1  one-cycle pulse when a key press is accepted
key_code  output  4  hex value of the last accepted key

Behaviour:
- Reset values: col_n=4'b1110, userInput=0, inputValid=0, digits=0, key_strobe=0, key_code=0, state=SCAN, dwell counter=0, debounce count=0.
- Synchronisation: row_n passes through a 2-flop synchroniser. All decisions use the synchronised rows.
- Tick: a dwell counter counts 0..SCAN_DIV-1. The tick is asserted when the count equals SCAN_DIV-1, then the counter wraps to 0.
- "Single hit" means exactly one synchronised row is low. Zero rows low, or two or more rows low, count as no key (ghosting is rejected).
- FSM, evaluated only on tick cycles unless stated otherwise:
  - SCAN:
    - Single hit: latch row index r and the current column c, debounce count=1, go to PRESS_DB. The column is held.
    - Otherwise: advance to the next column (0->1->2->3->0, col_n rotates left), stay in SCAN.
  - PRESS_DB:
    - Same single row r low: count++. When the count reaches DEBOUNCE, accept the key and go to HELD.
    - Anything else: return to SCAN and advance the column.
  - HELD:
    - No rows low: count=1, go to REL_DB.
    - Otherwise: stay. There is no auto-repeat.
  - REL_DB:
    - No rows low: count++. When the count reaches DEBOUNCE, go to SCAN and advance the column.
    - Any row low: go back to HELD.
- Accept: in the accept cycle, the following registered outputs all update on the same clock edge and are visible the next cycle:
  - key_strobe=1 for that one cycle;
  - key_code=KEYMAP[r][c];
  - userInput <= {userInput[11:0], key};
  - digits <= min(digits+1, 4);
  - inputValid <= 1.
- Overflow: with a fifth or later digit, the oldest nibble is shifted out; digits stays at 4.
- clear alone: userInput=0, digits=0, inputValid=0 on the next edge.
- clear in the same cycle as accept: the clear is applied first, then the digit. Result is userInput={12'h000,key}, digits=1, inputValid=1.
- Press latency: from the synchronised press to key_strobe is at most (SCAN_DIV x (DEBOUNCE+4)) clocks.
- Column drive is combinational from the registered column index, so col_n has no glitch-free requirement beyond being registered-index-derived.
- A mid-operation rst_n assertion aborts any debounce and returns all registers to their reset values immediately. No strobe is emitted.

Decomposition:
- Package keypad_pkg:
  - FSM state encoding: SCAN=2'd0, PRESS_DB=2'd1, HELD=2'd2, REL_DB=2'd3.
  - Constant KEYMAP[4][4], by row:
    - row0: 1,2,3,A
    - row1: 4,5,6,B
    - row2: 7,8,9,C
    - row3: E,0,F,D
  - Function onehot_row_index returning {valid, idx}.
- Sub-module sync_2ff (parameterised width): used for row_n. Scanning, debounce and the entry register stay in the top module.

Test Plan:
(Sim parameters: SCAN_DIV=4, DEBOUNCE=3.)
- Reset, then hold no key for 64 clocks -> col_n cycles 1110,1101,1011,0111 every 4 clocks; userInput=0, inputValid=0, key_strobe never asserted.
- Press row1 while col2 is driven, held 40 clocks then released -> exactly one key_strobe, key_code=6, userInput=16'h0006, digits=1, inputValid=1.
- Enter keys 1,2,3,A,5 with clean press/release -> userInput 0001, 0012, 0123, 123A, 23A5; digits saturates at 4.
- Bounce: row toggles low/high on alternate ticks for 10 ticks, then stable low -> no strobe during bouncing; one strobe only after 3 consecutive stable ticks; no repeat while held for 200 clocks.
- Two rows low together on one column -> no strobe; FSM stays in SCAN.
- Entry=16'h00AB with clear pulsed on the accept cycle of key 7 -> userInput=16'h0007, digits=1, inputValid=1. A standalone clear afterwards -> all zero. Asserting rst_n low during PRESS_DB -> no strobe; outputs at reset values.
